// File: rtl/keypad_scanner_if.sv
// Keypad matrix and key-event bundle between the scanner (master) and the keypad/consumer side (slave).
interface keypad_scanner_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   modport master (input row, output col, output key_code, output key_valid, output key_down);
   modport slave  (output row, input col, input key_code, input key_valid, input key_down);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, debounce, key event strobe.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int REPEAT_DELAY = 40,
   parameter int REPEAT_RATE  = 8
) (
   input  logic clk,
   input  logic rst,
   keypad_scanner_if.master kp
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

   if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("keypad_scanner: parameter out of range");
   end

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

   state_t           state_q;
   logic [3:0]       row_meta_q;
   logic [3:0]       row_s_q;
   logic [DIV_W-1:0] div_q;
   logic [3:0]       col_q;
   logic [3:0]       key_code_q;
   logic             key_valid_q;
   logic             key_down_q;
   logic [1:0]       row_idx_q;
   logic [DEB_W-1:0] match_q;
   logic [DEB_W-1:0] release_q;

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_q;
   logic             rep_armed_q;
   logic [REP_W-1:0] rep_target;

   // First repeat waits the long delay, later ones use the shorter rate.
   assign rep_target = rep_armed_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
`endif

   logic       tick;
   logic       key_ok;
   logic       same_key;
   logic       accept;
   logic [1:0] row_idx;
   logic [1:0] col_idx;
   logic [3:0] col_d;

   always_comb begin
      tick    = (div_q == DIV_W'(SCAN_DIV - 1));
      key_ok  = 1'b0;
      row_idx = 2'd0;
      // Only a single low row is a key; none or several is treated as idle.
      case (row_s_q)
         4'b1110: begin key_ok = 1'b1; row_idx = 2'd0; end
         4'b1101: begin key_ok = 1'b1; row_idx = 2'd1; end
         4'b1011: begin key_ok = 1'b1; row_idx = 2'd2; end
         4'b0111: begin key_ok = 1'b1; row_idx = 2'd3; end
         default: ;
      endcase
      case (col_q)
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
      col_d    = {col_q[2:0], col_q[3]};
      same_key = key_ok && (row_idx == row_idx_q);
      accept   = 1'b0;
      if (tick) begin
         if (state_q == SCAN && key_ok && DEBOUNCE_CNT == 1)
            accept = 1'b1;
         if (state_q == DEBOUNCE && same_key && (match_q + DEB_W'(1) == DEB_W'(DEBOUNCE_CNT)))
            accept = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= SCAN;
         row_meta_q  <= 4'hF;
         row_s_q     <= 4'hF;
         div_q       <= '0;
         col_q       <= 4'b1110;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
         row_idx_q   <= 2'd0;
         match_q     <= '0;
         release_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
         rep_q       <= '0;
         rep_armed_q <= 1'b0;
`endif
      end else begin
         row_meta_q  <= kp.row;
         row_s_q     <= row_meta_q;
         div_q       <= tick ? '0 : div_q + DIV_W'(1);
         key_valid_q <= 1'b0;

         if (accept) begin
            state_q     <= HOLD;
            key_code_q  <= {row_idx, col_idx};
            key_valid_q <= 1'b1;
            key_down_q  <= 1'b1;
            row_idx_q   <= row_idx;
            release_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
`endif
         end else if (tick) begin
            case (state_q)
               SCAN: begin
                  if (key_ok) begin
                     state_q   <= DEBOUNCE;
                     row_idx_q <= row_idx;
                     match_q   <= DEB_W'(1);
                  end else begin
                     col_q <= col_d;
                  end
               end
               DEBOUNCE: begin
                  if (same_key) begin
                     match_q <= match_q + DEB_W'(1);
                  end else begin
                     state_q <= SCAN;
                     col_q   <= col_d;
                  end
               end
               HOLD: begin
                  if (key_ok) begin
                     release_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                     if (same_key) begin
                        if (rep_q + REP_W'(1) == rep_target) begin
                           key_valid_q <= 1'b1;
                           rep_q       <= '0;
                           rep_armed_q <= 1'b1;
                        end else begin
                           rep_q <= rep_q + REP_W'(1);
                        end
                     end
`endif
                  end else if (release_q + DEB_W'(1) == DEB_W'(DEBOUNCE_CNT)) begin
                     state_q    <= SCAN;
                     key_down_q <= 1'b0;
                     col_q      <= col_d;
                     release_q  <= '0;
`ifdef KEYPAD_REPEAT_EN
                     rep_q       <= '0;
                     rep_armed_q <= 1'b0;
`endif
                  end else begin
                     release_q <= release_q + DEB_W'(1);
                  end
               end
               default: state_q <= SCAN;
            endcase
         end
      end
   end

   assign kp.col       = col_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows from the column lines, and
// an arithmetic timing model predicts col, key_valid, key_down and key_code every cycle.
`timescale 1ns/1ps
module tb_keypad_scanner;
   localparam int S  = 4;
   localparam int D  = 3;
   localparam int RD = 5;
   localparam int RR = 2;
`ifdef KEYPAD_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] pressed = '0;
   logic [3:0]  row_drv;

   int checks = 0;
   int fails  = 0;
   int k = 0;          // cycle index since the last reset release
   int b = 0;          // cycle at which the current idle scan run starts (multiple of S)
   int c0 = 0;         // column driven at cycle b
   int last_code = 0;

   keypad_scanner_if kp_bus ();

   keypad_scanner #(
      .SCAN_DIV(S), .DEBOUNCE_CNT(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .kp (kp_bus)
   );

   always #5 clk = ~clk;

   // Pressed key (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_drv = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kp_bus.col[c]) row_drv[r] = 1'b0;
   end
   assign kp_bus.row = row_drv;

   function automatic int idle_col(input int m);
      return (c0 + (m - b) / S) % 4;
   endfunction

   function automatic logic [3:0] col_pat(input int ci);
      logic [3:0] p;
      p = 4'hF;
      p[ci] = 1'b0;
      return p;
   endfunction

   task automatic step();
      @(negedge clk);
      k++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks += 4;
      if (kp_bus.col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b want 1110", kp_bus.col); end
      if (kp_bus.key_code !== 4'd0) begin fails++; $display("FAIL reset_code: got %0d want 0", kp_bus.key_code); end
      if (kp_bus.key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", kp_bus.key_valid); end
      if (kp_bus.key_down !== 1'b0) begin fails++; $display("FAIL reset_down: got %b want 0", kp_bus.key_down); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      k = 0; b = 0; c0 = 0; last_code = 0;
   endtask

   task automatic test_idle_scan(input int n);
      for (int i = 0; i < n; i++) begin
         checks += 2;
         if (kp_bus.col !== col_pat(idle_col(k))) begin
            fails++; $display("FAIL idle_col: cycle %0d got %b want %b", k, kp_bus.col, col_pat(idle_col(k)));
         end
         if (kp_bus.key_valid !== 1'b0) begin
            fails++; $display("FAIL idle_valid: cycle %0d got %b want 0", k, kp_bus.key_valid);
         end
         step();
      end
   endtask

   // Press key after 'delay' idle cycles, release 'extra' cycles after the expected strobe.
   task automatic test_press(input int key, input int delay, input int extra);
      int r, c, p, t, a, v, q, u, f, n, pulses, exp_pulses, exp_col, exp_code;
      logic exp_valid, exp_down;
      r = key / 4;
      c = key % 4;
      p = k + delay;
      while (k < p) begin
         checks++;
         if (kp_bus.col !== col_pat(idle_col(k))) begin
            fails++; $display("FAIL press_idle_col: cycle %0d got %b want %b", k, kp_bus.col, col_pat(idle_col(k)));
         end
         step();
      end
      pressed[key] = 1'b1;
      t = p + 2;
      while (!(t % S == S - 1 && idle_col(t) == c)) t++;
      a = t + (D - 1) * S;
      v = a + 1;
      q = v + extra;
      u = q + 2;
      while (u % S != S - 1) u++;
      f = u + (D - 1) * S + 1;
      pulses = 0;
      exp_pulses = 0;
      while (k < f + 2 * S) begin
         if (k == q) pressed[key] = 1'b0;
         exp_valid = (k == v);
         if (REP_EN && k > v + 1 && k - 1 <= q + 1 && (k - 1 - a) % S == 0) begin
            n = (k - 1 - a) / S;
            if (n >= RD && (n - RD) % RR == 0) exp_valid = 1'b1;
         end
         exp_down = (k >= v) && (k < f);
         exp_col  = (k <= t) ? idle_col(k) : ((k < f) ? c : (c + 1 + (k - f) / S) % 4);
         exp_code = (k >= v) ? key : last_code;
         if (exp_valid) exp_pulses++;
         if (kp_bus.key_valid === 1'b1) pulses++;
         checks += 4;
         if (kp_bus.key_valid !== exp_valid) begin
            fails++; $display("FAIL press_valid: key %0d cycle %0d got %b want %b", key, k, kp_bus.key_valid, exp_valid);
         end
         if (kp_bus.key_down !== exp_down) begin
            fails++; $display("FAIL press_down: key %0d cycle %0d got %b want %b", key, k, kp_bus.key_down, exp_down);
         end
         if (kp_bus.col !== col_pat(exp_col)) begin
            fails++; $display("FAIL press_col: key %0d cycle %0d got %b want %b", key, k, kp_bus.col, col_pat(exp_col));
         end
         if (kp_bus.key_code !== 4'(exp_code)) begin
            fails++; $display("FAIL press_code: key %0d cycle %0d got %0d want %0d", key, k, kp_bus.key_code, exp_code);
         end
         step();
      end
      checks++;
      if (pulses != exp_pulses) begin
         fails++; $display("FAIL press_pulse_count: key %0d got %0d want %0d", key, pulses, exp_pulses);
      end
      $display("press key=%0d detect=%0d strobe=%0d release=%0d keyup=%0d pulses=%0d", key, t, v, q, f, pulses);
      last_code = key;
      b  = f;
      c0 = (c + 1) % 4;
   endtask

   // Key held for only two matching sample ticks: must be rejected and scanning resumes.
   task automatic test_bounce(input int key);
      int c, p, t, q, e, exp_col;
      c = key % 4;
      p = k;
      pressed[key] = 1'b1;
      t = p + 2;
      while (!(t % S == S - 1 && idle_col(t) == c)) t++;
      q = t + S - 1;
      e = t + 2 * S + 1;
      while (k < e + 3 * S) begin
         if (k == q) pressed[key] = 1'b0;
         exp_col = (k <= t) ? idle_col(k) : ((k < e) ? c : (c + 1 + (k - e) / S) % 4);
         checks += 3;
         if (kp_bus.key_valid !== 1'b0) begin
            fails++; $display("FAIL bounce_valid: key %0d cycle %0d got %b want 0", key, k, kp_bus.key_valid);
         end
         if (kp_bus.key_down !== 1'b0) begin
            fails++; $display("FAIL bounce_down: key %0d cycle %0d got %b want 0", key, k, kp_bus.key_down);
         end
         if (kp_bus.col !== col_pat(exp_col)) begin
            fails++; $display("FAIL bounce_col: key %0d cycle %0d got %b want %b", key, k, kp_bus.col, col_pat(exp_col));
         end
         step();
      end
      $display("bounce key=%0d detect=%0d rescan=%0d", key, t, e);
      b  = e;
      c0 = (c + 1) % 4;
   endtask

   // Two rows low in the same column is not a key: scanning is unaffected.
   task automatic test_multi_row(input int c, input int r1, input int r2);
      pressed[r1*4+c] = 1'b1;
      pressed[r2*4+c] = 1'b1;
      for (int i = 0; i < 36; i++) begin
         if (i == 32) pressed = '0;
         checks += 3;
         if (kp_bus.key_valid !== 1'b0) begin
            fails++; $display("FAIL multi_valid: cycle %0d got %b want 0", k, kp_bus.key_valid);
         end
         if (kp_bus.key_down !== 1'b0) begin
            fails++; $display("FAIL multi_down: cycle %0d got %b want 0", k, kp_bus.key_down);
         end
         if (kp_bus.col !== col_pat(idle_col(k))) begin
            fails++; $display("FAIL multi_col: cycle %0d got %b want %b", k, kp_bus.col, col_pat(idle_col(k)));
         end
         step();
      end
      $display("multi col=%0d rows=%0d,%0d", c, r1, r2);
   endtask

   // Reset while a key is held; the still-held key must be detected again afterwards.
   task automatic test_reset_mid_hold(input int key);
      int c, t, v;
      c = key % 4;
      pressed[key] = 1'b1;
      t = k + 2;
      while (!(t % S == S - 1 && idle_col(t) == c)) t++;
      v = t + (D - 1) * S + 1;
      while (k < v + 3) step();
      checks += 2;
      if (kp_bus.key_down !== 1'b1) begin fails++; $display("FAIL midhold_down: got %b want 1", kp_bus.key_down); end
      if (kp_bus.key_code !== 4'(key)) begin fails++; $display("FAIL midhold_code: got %0d want %0d", kp_bus.key_code, key); end
      rst = 1'b0;
      #1;
      checks += 4;
      if (kp_bus.col !== 4'b1110) begin fails++; $display("FAIL midrst_col: got %b want 1110", kp_bus.col); end
      if (kp_bus.key_code !== 4'd0) begin fails++; $display("FAIL midrst_code: got %0d want 0", kp_bus.key_code); end
      if (kp_bus.key_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", kp_bus.key_valid); end
      if (kp_bus.key_down !== 1'b0) begin fails++; $display("FAIL midrst_down: got %b want 0", kp_bus.key_down); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      k = 0; b = 0; c0 = 0; last_code = 0;
      $display("reset mid-hold key=%0d", key);
      test_press(key, 0, 10);
   endtask

   task automatic test_repeat();
      test_press(15, int'($urandom_range(0, 6)), 60);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++)
         test_press(int'($urandom_range(0, 15)), int'($urandom_range(0, 10)), int'($urandom_range(0, 40)));
   endtask

   initial begin
      int cr, r1;
      test_reset();
      test_idle_scan(40);
      test_press(9, 0, 40);
      test_bounce(0);
      test_bounce(int'($urandom_range(0, 15)));
      test_multi_row(2, 0, 2);
      cr = int'($urandom_range(0, 3));
      r1 = int'($urandom_range(0, 3));
      test_multi_row(cr, r1, (r1 + 1 + int'($urandom_range(0, 2))) % 4);
      test_reset_mid_hold(5);
      test_repeat();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the column lines and reads the row lines of the 4x4 matrix keypad, which the top level exposes as the row/col pair.
- Synchronises and debounces the row inputs.
- Reports each confirmed key press as a 4-bit code with a one-cycle valid strobe, plus a held-key level.
- Consumed by the time-setting logic in place of raw row/col handling.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is driven (dwell); last dwell cycle is the sample tick; minimum 2.
- DEBOUNCE_CNT, 4, consecutive matching sample ticks needed to accept a press or a release; minimum 1.
- REPEAT_DELAY, 40, sample ticks in HOLD before the first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_RATE, 8, sample ticks between later auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows, active-low (pulled up externally; 4'hF = no key).
- col  output 4  column drive, one-hot active-low.
- key_code  output 4  code of the last accepted key = row_idx*4 + col_idx.
- key_valid  output 1  one-cycle pulse per accepted press (and per auto-repeat).
- key_down  output 1  high while an accepted key is held.

Behaviour:
- Reset (rst=0, asynchronous):
  - col=4'b1110, key_code=0, key_valid=0, key_down=0.
  - State SCAN, all counters 0, synchroniser flops = 4'hF.
- row passes through a 2-flop synchroniser (row_s); all decisions use row_s.
- Dwell counter runs 0..SCAN_DIV-1 continuously. tick = (counter == SCAN_DIV-1).
- Valid single key: exactly one bit of row_s low. row_idx = index of the low bit; col_idx = index of the low col bit.
- Zero low bits, or two or more low bits, count as "no key".
- SCAN state:
  - On tick with no key: rotate col 1110->1101->1011->0111->1110.
  - On tick with a valid key: latch row_idx/col_idx, freeze col, set match count=1, go DEBOUNCE.
- DEBOUNCE state, on each tick:
  - Same key: increment match count. When it reaches DEBOUNCE_CNT, go HOLD and register key_code and key_valid=1 for exactly the next cycle.
  - Anything else: return to SCAN and advance col.
  - With DEBOUNCE_CNT=1, acceptance happens on the detection tick itself.
- Press latency: key_valid rises 1 cycle after the (DEBOUNCE_CNT)th matching tick, i.e. (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles after the detection tick.
- HOLD state:
  - key_down=1; col stays frozen.
  - On each tick, count consecutive "no key" samples; any key sample resets the count.
  - When the count reaches DEBOUNCE_CNT: key_down=0, go SCAN, advance col.
- key_code holds its value until the next accepted key. key_valid is 0 in every other cycle.
- A different key pressed while the first is held is ignored until release completes.
- Reset asserted mid-press or mid-debounce forces reset values immediately. After reset release, a still-held key is detected afresh and produces a new pulse.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HOLD, a repeat counter counts ticks while the key stays valid.
  - At REPEAT_DELAY ticks, key_valid pulses once (same key_code). After that it pulses every REPEAT_RATE ticks.
  - Counter clears on leaving HOLD or on reset.
- Undefined: no repeat logic is synthesised; exactly one pulse per press; REPEAT_* parameters are unused.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3 unless noted):
1. Reset and idle:
   - Hold rst=0 -> col=1110, key_code=0, key_valid=0, key_down=0.
   - Release with row=4'hF -> col steps 1110,1101,1011,0111,1110, each held 4 cycles.
2. Clean press:
   - Pull row[2] low only while col=1101, held 40 cycles -> exactly one key_valid pulse, key_code=9.
   - Pulse lands 9 cycles after the detection tick; key_down=1 until release.
   - Release row to 4'hF -> key_down falls after 3 no-key ticks, then scanning resumes.
3. Bounce: row[0] low at col=1110 for 2 ticks, then high -> no key_valid, key_down stays 0, col advances to 1101.
4. Multi-row: row=4'b1010 while col=1011 for 30 cycles -> no key_valid; scanning continues.
5. Reset mid-HOLD: key 5 held, key_down=1; pulse rst low 3 cycles -> outputs at reset values immediately. Key still held -> new detection and a second pulse with key_code=5.
6. KEYPAD_REPEAT_EN defined, REPEAT_DELAY=5, REPEAT_RATE=2: hold key 15 -> initial pulse, then pulses 5 ticks later and every 2 ticks after that, all with key_code=15; none after release.
